uart_tx_fifo: RTL

Synthesizable, parametrised UART transmitter with a small input FIFO and valid/ready write handshake.
- Generalises the fixed 8N1 serial source used by SOC-level benches: configurable divider, data bits, parity, stop bits and buffer depth.
- Sits between the CPU/SOC bus side and the board TX pin; also serves as the reusable stimulus source for SOC RX testing.

---
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a small valid/ready FIFO
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   in_data/in_valid word to queue, accepted when in_valid && in_ready
//   in_ready         FIFO not full
//   tx               registered serial line, idle high
//   busy             high from START entry through the last STOP cycle
//   tx_done          one-cycle pulse on the last cycle of the final stop bit
//   fifo_level       number of queued words
//   break_req        only with UART_TX_BREAK_EN: hold tx low between frames
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_BITS-1:0]              in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
`ifdef UART_TX_BREAK_EN
    input  logic                              break_req,
`endif
    output logic                              tx,
    output logic                              busy,
    output logic                              tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wp, rp;
    logic [CW-1:0]        cnt;
    logic [3:0]           bidx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 push, pop, pop_ok, bit_end, last_stop;

    assign in_ready  = fifo_level != LW'(FIFO_DEPTH);
    assign push      = in_valid && in_ready;
    assign bit_end   = cnt == CW'(CLKS_PER_BIT - 1);
    assign last_stop = state == STOP && bidx == 4'(STOP_BITS - 1);
    // A pop starts a frame: from IDLE, or straight out of the final stop bit
    assign pop = fifo_level != '0 && pop_ok && (state == IDLE || (last_stop && bit_end));

`ifdef UART_TX_BREAK_EN
    logic brk, mab;
    // No start while break is requested, held, or during the mark-after-break bit;
    // the last mark cycle may launch the start so the mark lasts one bit exactly
    assign pop_ok = !break_req && !brk && (!mab || bit_end);
`else
    assign pop_ok = 1'b1;
`endif

    always_ff @(posedge clk)
        if (push) mem[wp] <= in_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bidx    <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk     <= 1'b0;
            mab     <= 1'b0;
`endif
        end else begin
            // Registered one cycle early so the pulse lands on the last stop cycle
            tx_done <= last_stop && cnt == CW'(CLKS_PER_BIT - 2);
            cnt     <= bit_end ? '0 : cnt + CW'(1);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    tx  <= 1'b1;
`ifdef UART_TX_BREAK_EN
                    if (break_req) begin
                        brk <= 1'b1;
                        mab <= 1'b0;
                        tx  <= 1'b0;
                    end else if (brk) begin
                        brk <= 1'b0;
                        mab <= 1'b1;
                    end else if (mab) begin
                        cnt <= bit_end ? '0 : cnt + CW'(1);
                        if (bit_end) mab <= 1'b0;
                    end
`endif
                end
                START: if (bit_end) begin
                    state <= DATA;
                    tx    <= shift[0];
                    bidx  <= '0;
                end
                DATA: if (bit_end) begin
                    shift <= shift >> 1;
                    tx    <= shift[1];
                    bidx  <= bidx + 4'(1);
                    if (bidx == 4'(DATA_BITS - 1)) begin
                        bidx  <= '0;
                        state <= PARITY != 0 ? PAR : STOP;
                        tx    <= PARITY != 0 ? par_bit : 1'b1;
                    end
                end
                PAR: if (bit_end) begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
                STOP: if (bit_end) begin
                    bidx <= bidx + 4'(1);
                    if (bidx == 4'(STOP_BITS - 1)) begin
                        bidx  <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef UART_TX_BREAK_EN
                        if (break_req) begin
                            tx  <= 1'b0;
                            brk <= 1'b1;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
            // Frame launch overrides the per-state updates above
            if (pop) begin
                state   <= START;
                tx      <= 1'b0;
                busy    <= 1'b1;
                cnt     <= '0;
                bidx    <= '0;
                shift   <= mem[rp];
                par_bit <= (^mem[rp]) ^ (PARITY == 2);
            end
        end
endmodule
